// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared types, constants and angle saturation for the servo sequencer
package servo_pkg;

    typedef logic signed [17:0] angle_t;
    typedef logic [11:0]        step_t;

    localparam int ANGLE_FRAC = 7;

    typedef enum logic {
        IDLE,
        UPDATE
    } seq_state_t;

    function automatic angle_t sat_angle(input angle_t a, input int lo, input int hi);
        if (int'(a) > hi) return angle_t'(hi);
        if (int'(a) < lo) return angle_t'(lo);
        return a;
    endfunction

endpackage

// File: rtl/servo_motion_sequencer_if.sv
// rtl/servo_motion_sequencer_if.sv - joint move command channel
interface servo_motion_sequencer_if #(
    parameter int NUM_JOINTS = 4
);
    import servo_pkg::*;

    localparam int JIDX_W = (NUM_JOINTS > 1) ? $clog2(NUM_JOINTS) : 1;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [JIDX_W-1:0] cmd_joint;
    angle_t            cmd_angle;
    step_t             cmd_step;

    modport master (output cmd_valid, cmd_joint, cmd_angle, cmd_step, input cmd_ready);
    modport slave  (input cmd_valid, cmd_joint, cmd_angle, cmd_step, output cmd_ready);

endinterface

// File: rtl/servo_frame_timer.sv
// rtl/servo_frame_timer.sv - free-running frame counter with a one-cycle boundary tick
module servo_frame_timer #(
    parameter int FRAME_CYCLES = 2_000_000
) (
    input  logic clock,
    input  logic reset,
    output logic frame_tick
);

    localparam int CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign frame_tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (frame_tick) cnt_d = '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/servo_motion_sequencer.sv
// rtl/servo_motion_sequencer.sv - per-frame ramping of commanded servo angles toward targets
module servo_motion_sequencer
    import servo_pkg::*;
#(
    parameter int NUM_JOINTS   = 4,
    parameter int FRAME_CYCLES = 2_000_000,
    parameter int MAX_ANGLE    = 60 << ANGLE_FRAC,
    parameter int MIN_ANGLE    = -(60 << ANGLE_FRAC)
) (
    input  logic                     clock,
    input  logic                     reset,
    servo_motion_sequencer_if.slave  cmd,
    output angle_t [NUM_JOINTS-1:0]  angle,
    output logic   [NUM_JOINTS-1:0]  en,
    output logic   [NUM_JOINTS-1:0]  moving,
    output logic                     all_idle,
    output logic                     frame_tick,
    output logic                     cmd_clamped,
    output logic                     cmd_bad_joint
);

    localparam int JIDX_W = (NUM_JOINTS > 1) ? $clog2(NUM_JOINTS) : 1;

    seq_state_t                state_q, state_d;
    logic [JIDX_W-1:0]         jidx_q, jidx_d;
    angle_t [NUM_JOINTS-1:0]   angle_q, angle_d;
    angle_t [NUM_JOINTS-1:0]   target_q, target_d;
    step_t  [NUM_JOINTS-1:0]   step_q, step_d;
    logic   [NUM_JOINTS-1:0]   en_q, en_d;
    logic   [NUM_JOINTS-1:0]   moving_q, moving_d;
    logic                      cmd_clamped_q, cmd_clamped_d;
    logic                      cmd_bad_joint_q, cmd_bad_joint_d;

    logic              accept;
    logic              bad_joint;
    angle_t            cmd_sat;
    angle_t            cur_angle, cur_target, step_ext, stepped;
    step_t             cur_step;
    logic signed [18:0] diff;
    logic [18:0]       abs_diff;

    servo_frame_timer #(.FRAME_CYCLES(FRAME_CYCLES)) u_timer (
        .clock      (clock),
        .reset      (reset),
        .frame_tick (frame_tick)
    );

    assign cmd.cmd_ready = (state_q == IDLE) && !reset;
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign bad_joint     = int'(cmd.cmd_joint) >= NUM_JOINTS;
    assign cmd_sat       = sat_angle(cmd.cmd_angle, MIN_ANGLE, MAX_ANGLE);

    // Single shared ramp datapath, muxed onto the joint selected by the sweep index.
    always_comb begin
        cur_angle  = '0;
        cur_target = '0;
        cur_step   = '0;
        for (int j = 0; j < NUM_JOINTS; j++) begin
            if (int'(jidx_q) == j) begin
                cur_angle  = angle_q[j];
                cur_target = target_q[j];
                cur_step   = step_q[j];
            end
        end
        diff     = {cur_target[17], cur_target} - {cur_angle[17], cur_angle};
        abs_diff = diff[18] ? -diff : diff;
        step_ext = {6'b0, cur_step};
        stepped  = diff[18] ? cur_angle - step_ext : cur_angle + step_ext;
    end

    always_comb begin
        state_d         = state_q;
        jidx_d          = jidx_q;
        angle_d         = angle_q;
        target_d        = target_q;
        step_d          = step_q;
        en_d            = en_q;
        moving_d        = moving_q;
        cmd_clamped_d   = 1'b0;
        cmd_bad_joint_d = 1'b0;

        if (accept) begin
            if (bad_joint) begin
                cmd_bad_joint_d = 1'b1;
            end else begin
                cmd_clamped_d = (cmd_sat != cmd.cmd_angle);
                for (int j = 0; j < NUM_JOINTS; j++) begin
                    if (int'(cmd.cmd_joint) == j) begin
                        target_d[j] = cmd_sat;
                        step_d[j]   = cmd.cmd_step;
                        en_d[j]     = 1'b1;
                        moving_d[j] = (cmd_sat != angle_q[j]);
                    end
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    state_d = UPDATE;
                    jidx_d  = '0;
                end
            end
            UPDATE: begin
                for (int j = 0; j < NUM_JOINTS; j++) begin
                    if (int'(jidx_q) == j && en_q[j]) begin
                        if (cur_step == '0 || abs_diff <= {7'b0, cur_step}) begin
                            angle_d[j]  = cur_target;
                            moving_d[j] = 1'b0;
                        end else begin
                            angle_d[j]  = stepped;
                        end
                    end
                end
                if (int'(jidx_q) == NUM_JOINTS - 1) state_d = IDLE;
                else                                jidx_d  = jidx_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            jidx_q          <= '0;
            angle_q         <= '0;
            target_q        <= '0;
            step_q          <= '0;
            en_q            <= '0;
            moving_q        <= '0;
            cmd_clamped_q   <= 1'b0;
            cmd_bad_joint_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            jidx_q          <= jidx_d;
            angle_q         <= angle_d;
            target_q        <= target_d;
            step_q          <= step_d;
            en_q            <= en_d;
            moving_q        <= moving_d;
            cmd_clamped_q   <= cmd_clamped_d;
            cmd_bad_joint_q <= cmd_bad_joint_d;
        end
    end

    assign angle         = angle_q;
    assign en            = en_q;
    assign moving        = moving_q;
    assign all_idle      = ~|moving_q;
    assign cmd_clamped   = cmd_clamped_q;
    assign cmd_bad_joint = cmd_bad_joint_q;

endmodule
